// File: rtl/tagged_reg_file.sv
// tagged_reg_file
//   Architectural register file for the out-of-order core. Each register holds
//   either a committed value or the reservation-station tag of the instruction
//   that will produce it. Tags are resolved by matching CDB broadcasts.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   ren_en/addr/tag       rename port: mark ren_addr busy with ren_tag
//   cdb_en/tag/data       CDB broadcast: resolve every busy register holding cdb_tag
//   flush                 clear all busy flags (mispredict recovery)
//   rd_addr               NUM_READ packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_is_tag             per port: 1 = rd_data carries a tag
//   rd_data               per port: value, or tag zero-extended to DATA_W
//   busy_cnt              number of registers currently holding a tag
//
// Handshake: none. Rename and CDB are single-cycle strobes qualified by their
// enables; there is no backpressure. Reads are combinational from pre-update
// state, with a bypass from the CDB but not from the rename port.
module tagged_reg_file #(
  parameter  int DATA_W   = 32,
  parameter  int REG_NUM  = 32,
  parameter  int TAG_W    = 4,
  parameter  int NUM_READ = 2,
  localparam int ADDR_W   = $clog2(REG_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ren_en,
  input  logic [ADDR_W-1:0]            ren_addr,
  input  logic [TAG_W-1:0]             ren_tag,
  input  logic                         cdb_en,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  input  logic                         flush,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ-1:0]          rd_is_tag,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [ADDR_W:0]              busy_cnt
);

  logic              busy_q [REG_NUM];
  logic [TAG_W-1:0]  tag_q  [REG_NUM];
  logic [DATA_W-1:0] val_q  [REG_NUM];

  logic              busy_d [REG_NUM];
  logic [TAG_W-1:0]  tag_d  [REG_NUM];
  logic [DATA_W-1:0] val_d  [REG_NUM];
  logic [ADDR_W:0]   cnt_d;

  // Next-state. Order of the updates encodes the priority:
  // CDB resolve, then rename (wins the busy/tag fields), then flush (wins busy).
  // The value field only ever comes from the CDB, so a CDB hit still lands
  // in val even when a rename or flush happens in the same cycle.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      busy_d[r] = busy_q[r];
      tag_d[r]  = tag_q[r];
      val_d[r]  = val_q[r];
    end
    for (int r = 1; r < REG_NUM; r++) begin
      if (cdb_en && busy_q[r] && (tag_q[r] == cdb_tag)) begin
        val_d[r]  = cdb_data;
        busy_d[r] = 1'b0;
      end
      if (ren_en && !flush && (ren_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
        tag_d[r]  = ren_tag;
      end
      if (flush) begin
        busy_d[r] = 1'b0;
      end
    end
    // Register 0 is hardwired to zero and never busy.
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
    val_d[0]  = '0;
  end

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < REG_NUM; r++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < REG_NUM; r++) begin
      if (rst) begin
        busy_q[r] <= 1'b0;
        tag_q[r]  <= '0;
        val_q[r]  <= '0;
      end else begin
        busy_q[r] <= busy_d[r];
        tag_q[r]  <= tag_d[r];
        val_q[r]  <= val_d[r];
      end
    end
    if (rst) begin
      busy_cnt <= '0;
    end else begin
      busy_cnt <= cnt_d;
    end
  end

  // Read ports: identical and independent.
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              is_tag_p;
    logic [DATA_W-1:0] data_p;

    assign a = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      is_tag_p = 1'b0;
      data_p   = '0;
      if (rst || (a == '0)) begin
        is_tag_p = 1'b0;
        data_p   = '0;
      end else if (busy_q[a] && cdb_en && (tag_q[a] == cdb_tag)) begin
        // Producer is broadcasting right now: hand the value straight over.
        data_p = cdb_data;
      end else if (busy_q[a]) begin
        is_tag_p = 1'b1;
        data_p   = DATA_W'(tag_q[a]);
      end else begin
        data_p = val_q[a];
      end
    end

    assign rd_is_tag[i]                = is_tag_p;
    assign rd_data[i*DATA_W +: DATA_W] = data_p;
  end

endmodule

// File: tb/tb_tagged_reg_file.sv
module tb_tagged_reg_file;

  localparam int DATA_W   = 32;
  localparam int REG_NUM  = 32;
  localparam int TAG_W    = 4;
  localparam int NUM_READ = 2;
  localparam int ADDR_W   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                       ren_en;
  logic [ADDR_W-1:0]          ren_addr;
  logic [TAG_W-1:0]           ren_tag;
  logic                       cdb_en;
  logic [TAG_W-1:0]           cdb_tag;
  logic [DATA_W-1:0]          cdb_data;
  logic                       flush;
  logic [NUM_READ*ADDR_W-1:0] rd_addr;
  logic [NUM_READ-1:0]        rd_is_tag;
  logic [NUM_READ*DATA_W-1:0] rd_data;
  logic [ADDR_W:0]            busy_cnt;

  int total = 0;
  int bad   = 0;

  tagged_reg_file #(
    .DATA_W(DATA_W), .REG_NUM(REG_NUM), .TAG_W(TAG_W), .NUM_READ(NUM_READ)
  ) dut (
    .clk(clk), .rst(rst),
    .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag),
    .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
    .rd_addr(rd_addr), .rd_is_tag(rd_is_tag), .rd_data(rd_data),
    .busy_cnt(busy_cnt)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_port(input string name, input int p, input logic is_tag, input logic [31:0] data);
    check({name, "_is_tag"}, {31'b0, rd_is_tag[p]}, {31'b0, is_tag});
    check({name, "_data"}, rd_data[p*DATA_W +: DATA_W], data);
  endtask

  task automatic check_cnt(input string name, input int exp);
    check(name, {26'b0, busy_cnt}, exp);
  endtask

  // ---------------- drivers ----------------
  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic idle();
    ren_en = 1'b0; cdb_en = 1'b0; flush = 1'b0;
  endtask

  task automatic rename(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
    ren_en = 1'b1; ren_addr = a; ren_tag = t;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_en = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    ren_en = 1'b0; ren_addr = '0; ren_tag = '0;
    cdb_en = 1'b0; cdb_tag = '0; cdb_data = '0;
    flush = 1'b0; rd_addr = '0;
    step(); step();

    // Reads while in reset
    set_rd(5, 31);
    check_port("rst_r5", 0, 1'b0, 32'h0);
    check_port("rst_r31", 1, 1'b0, 32'h0);
    rst = 1'b0;
    set_rd(0, 5);
    check_port("post_rst_r0", 0, 1'b0, 32'h0);
    check_port("post_rst_r5", 1, 1'b0, 32'h0);
    set_rd(31, 31);
    check_port("post_rst_r31", 0, 1'b0, 32'h0);
    check_cnt("post_rst_cnt", 0);

    // Rename r3 -> tag 7, then resolve via CDB with bypass
    rename(3, 7);
    set_rd(3, 3);
    check_port("r3_pre_rename", 0, 1'b0, 32'h0);
    step(); idle(); #1;
    check_port("r3_tag", 0, 1'b1, 32'h7);
    check_port("r3_tag_p1", 1, 1'b1, 32'h7);
    check_cnt("r3_cnt1", 1);
    cdb(7, 32'hDEADBEEF); #1;
    check_port("r3_bypass", 0, 1'b0, 32'hDEADBEEF);
    step(); idle(); #1;
    check_port("r3_val", 0, 1'b0, 32'hDEADBEEF);
    check_cnt("r3_cnt0", 0);

    // Two registers sharing one tag resolve together
    rename(4, 2); step();
    rename(9, 2); step(); idle(); #1;
    check_cnt("dup_cnt2", 2);
    set_rd(4, 9);
    check_port("r4_tag", 0, 1'b1, 32'h2);
    cdb(2, 32'h55); #1;
    check_port("r4_bypass", 0, 1'b0, 32'h55);
    check_port("r9_bypass", 1, 1'b0, 32'h55);
    step(); idle(); #1;
    check_port("r4_val", 0, 1'b0, 32'h55);
    check_port("r9_val", 1, 1'b0, 32'h55);
    check_cnt("dup_cnt0", 0);

    // Rename beats CDB on the same register
    rename(6, 1); step(); idle(); #1;
    check_cnt("r6_cnt1", 1);
    rename(6, 3); cdb(1, 32'h11);
    set_rd(6, 6);
    step(); idle(); #1;
    check_port("r6_retag", 0, 1'b1, 32'h3);
    check_cnt("r6_cnt_still1", 1);
    cdb(3, 32'h22); step(); idle(); #1;
    check_port("r6_val", 0, 1'b0, 32'h22);
    check_cnt("r6_cnt0", 0);

    // Flush beats rename; CDB value still lands
    rename(1, 1); step();
    rename(2, 2); step();
    rename(3, 3); step(); idle(); #1;
    check_cnt("fl_cnt3", 3);
    flush = 1'b1; rename(8, 4); cdb(2, 32'h99);
    step(); idle(); #1;
    check_cnt("fl_cnt0", 0);
    set_rd(8, 2);
    check_port("fl_r8", 0, 1'b0, 32'h0);
    check_port("fl_r2", 1, 1'b0, 32'h99);
    set_rd(1, 3);
    check_port("fl_r1", 0, 1'b0, 32'h0);
    check_port("fl_r3", 1, 1'b0, 32'hDEADBEEF);

    // Register 0 ignores renames
    rename(0, 5); step(); idle(); #1;
    set_rd(0, 0);
    check_port("r0_after_ren", 0, 1'b0, 32'h0);
    check_cnt("r0_cnt", 0);

    // No bypass from rename port
    rename(10, 6); step(); idle();
    cdb(6, 32'hA5A5); step(); idle(); #1;
    set_rd(10, 10);
    check_port("r10_val", 0, 1'b0, 32'hA5A5);
    rename(10, 5); #1;
    check_port("r10_no_ren_bypass", 0, 1'b0, 32'hA5A5);
    check_port("r10_no_ren_bypass_p1", 1, 1'b0, 32'hA5A5);
    step(); idle(); #1;
    check_port("r10_tag5", 0, 1'b1, 32'h5);
    check_cnt("r10_cnt1", 1);

    // Reset while a tag is pending
    rst = 1'b1; step(); rst = 1'b0; #1;
    set_rd(10, 3);
    check_port("rst2_r10", 0, 1'b0, 32'h0);
    check_port("rst2_r3", 1, 1'b0, 32'h0);
    check_cnt("rst2_cnt", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tagged_reg_file.md
Name: tagged_reg_file

Overview:
- Architectural register file for the out-of-order core; holds per-register either a committed value or the reservation-station tag of its pending producer.
- Parametrised successor to the two-port tag/value regfile:
  - N read ports.
  - Separate rename (tag-write) port.
  - Common-data-bus (CDB) broadcast port that resolves tags by match.
  - Global tag flush for mispredict recovery.
  - Pending-register counter.
- Sits between decode/dispatch and the reservation stations.

Parameters:
- DATA_W, 32, value width.
- REG_NUM, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero.
- TAG_W, 4, reservation-station tag width.
- NUM_READ, 2, number of read ports (>=1).
- ADDR_W (local), log2(REG_NUM), register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ren_en  in  1  rename write enable.
- ren_addr  in  ADDR_W  destination register being renamed.
- ren_tag  in  TAG_W  tag assigned to ren_addr.
- cdb_en  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  producing tag.
- cdb_data  in  DATA_W  produced value.
- flush  in  1  clear all pending tags.
- rd_addr  in  NUM_READ*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W].
- rd_is_tag  out  NUM_READ  1 = port i returns a tag.
- rd_data  out  NUM_READ*DATA_W  port i value, or tag zero-extended to DATA_W.
- busy_cnt  out  ADDR_W+1  number of registers currently holding a tag.

Behaviour:
- Reset is synchronous and active-high (rst sampled on posedge clk):
  - All values, tags and busy flags cleared.
  - busy_cnt=0.
  - Reads during reset return rd_is_tag=0, rd_data=0.
- State per register r: busy[r], tag[r] (TAG_W), val[r] (DATA_W).
  - Register 0 is never busy and always reads value 0.
  - Writes to register 0 are ignored.
- CDB update, on posedge when cdb_en:
  - Every r with busy[r] && tag[r]==cdb_tag gets val[r]<=cdb_data and busy[r]<=0.
  - Multiple matching registers are all updated in the same cycle.
- Rename update, on posedge when ren_en && ren_addr!=0: busy[ren_addr]<=1, tag[ren_addr]<=ren_tag.
- Same-cycle priority on one register:
  - Rename beats CDB: the register ends busy with the new tag; val still takes cdb_data if the old tag matched.
  - flush beats rename: all busy<=0, rename discarded, tags left unchanged.
  - CDB value writes still apply during a flush cycle.
- Reads are combinational, zero latency, pre-update state with CDB bypass:
  - Addr 0 -> is_tag=0, data=0.
  - Else if busy && cdb_en && tag==cdb_tag -> is_tag=0, data=cdb_data.
  - Else if busy -> is_tag=1, data=tag.
  - Else -> is_tag=0, data=val.
  - No bypass from the rename port: an instruction's sources see the mapping before its own rename, including when rd_addr==ren_addr.
- busy_cnt reflects registered state (updated on posedge, one-cycle latency after rename/CDB).
  - Computed as population count of busy each cycle or as next-state count.
  - Range 0..REG_NUM-1.
  - Flush -> 0 next cycle.
- Tag reuse: a tag may be renamed again only after its CDB broadcast; a duplicate live tag is outside the contract (all matching registers resolve together).
- All read ports are independent and identical; same address on multiple ports returns identical results.

Test Plan:
- rst=1 then release; read regs 0,5,31 -> rd_is_tag=0, rd_data=0, busy_cnt=0.
- Rename r3 to tag 7, next cycle read r3 -> is_tag=1, data=7, busy_cnt=1; CDB tag 7 data 0xDEADBEEF, same-cycle read r3 -> is_tag=0, data=0xDEADBEEF (bypass); next cycle still 0xDEADBEEF, busy_cnt=0.
- Rename r4 tag 2 and r9 tag 2, CDB tag 2 data 0x55 -> both read 0x55, busy_cnt 2->0.
- r6 busy tag 1; same cycle rename r6 tag 3 and CDB tag 1 data 0x11 -> next cycle r6 is_tag=1, data=3, busy_cnt=1; then CDB tag 3 data 0x22 -> r6 reads 0x22.
- Rename r1,r2,r3 (tags 1..3), busy_cnt=3; flush with simultaneous rename r8 tag 4 and CDB tag 2 data 0x99 -> busy_cnt=0, r8 not busy, r2 reads 0x99, r1/r3 read old values.
- Rename r0 tag 5 -> r0 reads 0, busy_cnt unchanged; rd_addr==ren_addr r10 in rename cycle -> port returns pre-rename value; rst asserted mid-pending -> all clear next cycle.
